game_state_store: RTL and testbench
===================================

Name: game_state_store

Overview:
- Holds the live Sokoban game state word and a bounded undo history.
- Acts as the responder to the game controller: executes the controller's `game_state_en`/`sel` commands (load stage, commit move, retract).
- Drives `game_state` back to the controller, the move logic and the renderer.
- Sits between the stage ROM, the move logic and the game controller.

Parameters:
- DEPTH, 16, number of undo entries retained; must be a power of two.
- PTR_W, 4, log2(DEPTH).
- STEP_W, 10, width of the step counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- game_state_en  input  1  command strobe from game controller; sampled every cycle
- sel  input  2  command: 0=load stage, 1=commit move, 2=reserved, 3=retract
- init_state  input  135  stage initial state from stage ROM
- next_state  input  135  candidate state from move logic
- game_state  output  135  current state: [134] moved flag, [133:70] way, [69:6] box, [5:0] player cell
- step_count  output  STEP_W  moves made since last load, net of retracts
- undo_avail  output  1  history holds at least one entry
- hist_depth  output  PTR_W+1  number of valid history entries, 0..DEPTH

Behaviour:
- Single clock domain; all outputs registered. Reset is synchronous and active-high; clock is `clk`, reset is `reset`.
- Reset values:
  - game_state = 0, step_count = 0, hist_depth = 0, undo_avail = 0.
  - Stack write pointer = 0.
  - History contents are don't-care and need no reset.
- Commands act only on cycles with game_state_en=1. Results are visible on the next rising edge (1-cycle latency). With game_state_en=0, all state holds.
- States: EMPTY (hist_depth=0), PARTIAL (0<depth<DEPTH), FULL (depth=DEPTH). Derived from hist_depth; no separate FSM register.
- LOAD (sel=0):
  - game_state <= {1'b0, init_state[133:0]}.
  - hist_depth <= 0, step_count <= 0, wr_ptr <= 0.
  - Any state -> EMPTY.
- MOVE (sel=1):
  - Push the current game_state at wr_ptr, then wr_ptr <= wr_ptr+1 (mod DEPTH).
  - game_state <= {1'b1, next_state[133:0]}.
  - hist_depth <= min(depth+1, DEPTH).
  - step_count <= step_count+1, saturating at all-ones.
- MOVE when FULL: oldest entry is overwritten (circular); depth stays DEPTH; wr_ptr still advances.
- RETRACT (sel=3) with depth>0:
  - game_state <= hist[wr_ptr-1].
  - wr_ptr <= wr_ptr-1 (mod DEPTH), hist_depth <= depth-1.
  - step_count <= step_count-1, floored at 0.
- RETRACT when EMPTY: no change to any register.
- sel=2: no-op.
- undo_avail = (hist_depth != 0), derived from the registered depth; updates the same cycle as hist_depth.
- reset asserted together with game_state_en: reset wins.
- Step counter saturated and a retract follows: decrements from all-ones. Accepted inaccuracy.
- Back-to-back commands on consecutive cycles are legal. Each uses the state produced by the previous cycle.
- Stack storage is a register array, read combinationally at wr_ptr-1, written synchronously.

Decomposition:
- Shared include `game_defs.vh`:
  - command codes SEL_LOAD=0, SEL_MOVE=1, SEL_RETRACT=3;
  - state-word field bounds WAY_HI=133, WAY_LO=70, BOX_HI=69, BOX_LO=6, POS_HI=5, POS_LO=0;
  - MOVED_BIT=134;
  - STATE_W=135.
- Sub-module `history_stack` (parameters DEPTH, PTR_W, WIDTH):
  - ports push, pop, clear, din, dout, depth;
  - circular overwrite-on-full;
  - pop-on-empty ignored.
- The top level holds game_state, step_count and command decode.

Test Plan:
1. Reset, then LOAD with init_state[133:0]=X -> next cycle game_state={0,X}, step_count=0, undo_avail=0, hist_depth=0.
2. LOAD X, MOVE with next_state=A, MOVE with next_state=B, then RETRACT twice:
   - after the two MOVEs: game_state[133:0]=B, step_count=2, hist_depth=2;
   - after the first RETRACT: game_state[133:0]=A;
   - after the second RETRACT: game_state={0,X}, step_count=0, undo_avail=0.
3. EMPTY + RETRACT, then game_state_en=0 with sel=1 -> game_state, step_count and hist_depth unchanged in both cycles.
4. LOAD S0, 17 MOVEs S1..S17 (DEPTH=16), then 17 RETRACTs:
   - after the MOVEs: hist_depth=16;
   - after 16 RETRACTs: game_state=S1 with moved bit 1, hist_depth=0;
   - the 17th RETRACT is ignored;
   - step_count=1.
5. game_state_en=1, sel=1 and reset=1 in the same cycle -> game_state=0 and hist_depth=0 next cycle. sel=2 with en=1 -> no change.
6. Alternate MOVE/RETRACT every cycle for 8 cycles starting from LOAD X, next_state=Y:
   - game_state toggles between {1,Y} and {0,X};
   - hist_depth toggles 1/0;
   - step_count toggles 1/0.

Source files
------------

// File: rtl/game_state_store_pkg.sv
// Shared command codes and state-word layout for the Sokoban game state store.
package game_state_store_pkg;

  typedef enum logic [1:0] {
    SEL_LOAD    = 2'd0,
    SEL_MOVE    = 2'd1,
    SEL_RSVD    = 2'd2,
    SEL_RETRACT = 2'd3
  } sel_e;

  localparam int STATE_W   = 135;
  localparam int MOVED_BIT = 134;
  localparam int WAY_HI    = 133;
  localparam int WAY_LO    = 70;
  localparam int BOX_HI    = 69;
  localparam int BOX_LO    = 6;
  localparam int POS_HI    = 5;
  localparam int POS_LO    = 0;

endpackage

// File: rtl/game_state_store_history_stack.sv
// Bounded undo stack: circular register array, overwrites oldest when full.
module history_stack #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4,
  parameter int WIDTH = 135
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [PTR_W:0]   depth
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign rd_ptr = wr_ptr - 1'b1;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      depth  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (depth != FULL) depth <= depth + 1'b1;
    end else if (pop && depth != '0) begin
      wr_ptr <= rd_ptr;
      depth  <= depth - 1'b1;
    end
  end

  // Contents need no reset; validity is tracked by depth alone.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/game_state_store.sv
// Live Sokoban state word plus undo history; executes load/move/retract commands.
module game_state_store
  import game_state_store_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4,
  parameter int STEP_W = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               game_state_en,
  input  logic [1:0]         sel,
  input  logic [STATE_W-1:0] init_state,
  input  logic [STATE_W-1:0] next_state,
  output logic [STATE_W-1:0] game_state,
  output logic [STEP_W-1:0]  step_count,
  output logic               undo_avail,
  output logic [PTR_W:0]     hist_depth
);

  logic               load, move, retract;
  logic [STATE_W-1:0] hist_top;
  logic               unused_moved;

  assign load    = game_state_en && (sel == SEL_LOAD);
  assign move    = game_state_en && (sel == SEL_MOVE);
  assign retract = game_state_en && (sel == SEL_RETRACT);

  // The moved flag is owned here, so the incoming copies are ignored.
  assign unused_moved = init_state[MOVED_BIT] ^ next_state[MOVED_BIT];

  assign undo_avail = (hist_depth != '0);

  history_stack #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .WIDTH (STATE_W)
  ) u_hist (
    .clk   (clk),
    .reset (reset),
    .push  (move),
    .pop   (retract),
    .clear (load),
    .din   (game_state),
    .dout  (hist_top),
    .depth (hist_depth)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      game_state <= '0;
      step_count <= '0;
    end else if (load) begin
      game_state <= {1'b0, init_state[WAY_HI:POS_LO]};
      step_count <= '0;
    end else if (move) begin
      game_state <= {1'b1, next_state[WAY_HI:POS_LO]};
      if (!(&step_count)) step_count <= step_count + 1'b1;
    end else if (retract && undo_avail) begin
      game_state <= hist_top;
      if (step_count != '0) step_count <= step_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_game_state_store.sv
// Scoreboard bench: stimulus queues expected state, monitor compares after each edge.
module tb_game_state_store;

  logic         clk = 1'b0;
  logic         reset;
  logic         game_state_en;
  logic [1:0]   sel;
  logic [134:0] init_state;
  logic [134:0] next_state;
  logic [134:0] game_state;
  logic [9:0]   step_count;
  logic         undo_avail;
  logic [4:0]   hist_depth;

  typedef struct packed {
    logic [134:0] gs;
    logic [9:0]   step;
    logic [4:0]   dep;
    logic         ua;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  game_state_store #(.DEPTH(16), .PTR_W(4), .STEP_W(10)) dut (
    .clk           (clk),
    .reset         (reset),
    .game_state_en (game_state_en),
    .sel           (sel),
    .init_state    (init_state),
    .next_state    (next_state),
    .game_state    (game_state),
    .step_count    (step_count),
    .undo_avail    (undo_avail),
    .hist_depth    (hist_depth)
  );

  function automatic logic [134:0] mk(input int seed);
    logic [134:0] v;
    v = '0;
    for (int k = 0; k < 5; k++) v[k*27 +: 27] = 27'((seed * 32'h9E3779B1) ^ (k * 32'h01234567) ^ seed);
    return v;
  endfunction

  function automatic logic [134:0] mv(input logic [134:0] s);
    return {1'b1, s[133:0]};
  endfunction

  function automatic logic [134:0] ld(input logic [134:0] s);
    return {1'b0, s[133:0]};
  endfunction

  task automatic drive(input logic rst, input logic en, input logic [1:0] s,
                       input logic [134:0] ns, input logic [134:0] is);
    @(negedge clk);
    reset = rst; game_state_en = en; sel = s; next_state = ns; init_state = is;
  endtask

  task automatic expect_st(input logic [134:0] gs, input int step, input int dep);
    exp_t e;
    e.gs = gs; e.step = 10'(step); e.dep = 5'(dep); e.ua = (dep != 0);
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are sampled 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (game_state !== e.gs || step_count !== e.step || hist_depth !== e.dep || undo_avail !== e.ua) begin
          errors++;
          $display("FAIL check%0d: got gs=%h step=%0d dep=%0d ua=%0b, want gs=%h step=%0d dep=%0d ua=%0b",
                   checks, game_state, step_count, hist_depth, undo_avail, e.gs, e.step, e.dep, e.ua);
        end
      end
    end
  end

  initial begin
    logic [134:0] x, a, b, y, z;
    x = mk(1); x[134] = 1'b1;   // moved bit must be cleared by LOAD
    a = mk(2); a[134] = 1'b0;   // moved bit must be set by MOVE
    b = mk(3);
    y = mk(4); y[134] = 1'b0;
    z = '0;
    reset = 1'b1; game_state_en = 1'b0; sel = 2'd0; init_state = '0; next_state = '0;

    // 1: reset, then load
    drive(1, 0, 0, z, z);            expect_st(z, 0, 0);
    drive(0, 1, 0, z, x);            expect_st(ld(x), 0, 0);

    // 2: two moves, two retracts
    drive(0, 1, 1, a, z);            expect_st(mv(a), 1, 1);
    drive(0, 1, 1, b, z);            expect_st(mv(b), 2, 2);
    drive(0, 1, 3, z, z);            expect_st(mv(a), 1, 1);
    drive(0, 1, 3, z, z);            expect_st(ld(x), 0, 0);

    // 3: retract on empty, then disabled move
    drive(0, 1, 3, z, z);            expect_st(ld(x), 0, 0);
    drive(0, 0, 1, a, b);            expect_st(ld(x), 0, 0);

    // 4: overfill the history, then drain it
    drive(0, 1, 0, z, mk(100));      expect_st(ld(mk(100)), 0, 0);
    for (int i = 1; i <= 17; i++) begin
      drive(0, 1, 1, mk(100 + i), z);
      expect_st(mv(mk(100 + i)), i, (i > 16) ? 16 : i);
    end
    for (int j = 1; j <= 16; j++) begin
      drive(0, 1, 3, z, z);
      expect_st(mv(mk(100 + 17 - j)), 17 - j, 16 - j);
    end
    drive(0, 1, 3, z, z);            expect_st(mv(mk(101)), 1, 0);

    // 5: reset beats a simultaneous move; reserved code is a no-op
    drive(1, 1, 1, a, z);            expect_st(z, 0, 0);
    drive(0, 1, 0, z, x);            expect_st(ld(x), 0, 0);
    drive(0, 1, 1, a, z);            expect_st(mv(a), 1, 1);
    drive(0, 1, 2, b, b);            expect_st(mv(a), 1, 1);

    // 6: alternating move/retract
    drive(0, 1, 0, z, x);            expect_st(ld(x), 0, 0);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        drive(0, 1, 1, y, z);        expect_st(mv(y), 1, 1);
      end else begin
        drive(0, 1, 3, z, z);        expect_st(ld(x), 0, 0);
      end
    end

    // step counter saturation, then a retract decrements from all-ones
    drive(0, 1, 0, z, x);            expect_st(ld(x), 0, 0);
    for (int i = 0; i < 1030; i++) drive(0, 1, 1, y, z);
    drive(0, 0, 0, z, z);            expect_st(mv(y), 1023, 16);
    drive(0, 1, 3, z, z);            expect_st(mv(y), 1022, 15);
    drive(0, 0, 0, z, z);

    for (int t = 0; t < 6 && exp_q.size() > 0; t++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
